fib_seq_gen: RTL

- Parametrised successor to the 8-bit two-register Fibonacci stepper. Emits a Fibonacci-style sequence a(n+1)=b, b(n+1)=a+b over a valid/ready stream.
- Adds a generic width, runtime-loadable seeds, a choice of wrap or stop on overflow, a sticky overflow flag and an element index.
- Sits as a stream source feeding downstream datapath or test blocks.

---
 rtl/fib_pkg.sv | 22 ++
 rtl/fib_step.sv | 25 ++
 rtl/fib_seq_gen.sv | 91 +++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types and arithmetic for the Fibonacci stream source.
// The FSM state encoding is fixed so that waveforms and debug taps stay stable.
package fib_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_LAST = 2'b01,
    ST_DONE = 2'b10
  } fsm_e;

  localparam bit MODE_WRAP = 1'b1;
  localparam bit MODE_STOP = 1'b0;

  // Widest supported element; callers zero-extend into this and slice back out.
  localparam int SUM_MAX_W = 64;

  function automatic logic [SUM_MAX_W:0] fib_sum(input logic [SUM_MAX_W-1:0] a,
                                                 input logic [SUM_MAX_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/fib_step.sv
// One Fibonacci step, purely combinational: next_a = b, next_b = a + b.
// In stop mode an overflowing sum leaves b untouched so the last element repeats cleanly.
module fib_step
  import fib_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit WRAP  = MODE_WRAP
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_next_a,
  output logic [WIDTH-1:0] o_next_b,
  output logic             o_carry
);

  logic [SUM_MAX_W:0] w_sum;

  assign w_sum = fib_sum(SUM_MAX_W'(i_a), SUM_MAX_W'(i_b));

  // Bits above WIDTH are zero except the carry; reducing them keeps every sum bit live.
  assign o_carry  = |w_sum[SUM_MAX_W:WIDTH];
  assign o_next_a = i_b;
  assign o_next_b = (WRAP || !o_carry) ? w_sum[WIDTH-1:0] : i_b;

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci valid/ready stream source with loadable seeds, wrap/stop overflow modes and an index.
// Element is presented the first cycle en=1 after reset/load; advances one per fire, held under backpressure.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int             WIDTH = 8,
  parameter int             CNT_W = 16,
  parameter logic [WIDTH-1:0] SEED0 = '0,
  parameter logic [WIDTH-1:0] SEED1 = WIDTH'(1),
  parameter bit             WRAP  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed_a,
  input  logic [WIDTH-1:0] i_seed_b,
  input  logic             i_en,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [CNT_W-1:0] o_out_idx,
  output logic             o_ovf,
  output logic             o_done
);

  fsm_e             r_fsm;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_idx;
  logic             r_ovf;
  logic             r_done;

  logic [WIDTH-1:0] w_next_a;
  logic [WIDTH-1:0] w_next_b;
  logic             w_carry;
  logic             w_fire;

  fib_step #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_step (
    .i_a      (r_a),
    .i_b      (r_b),
    .o_next_a (w_next_a),
    .o_next_b (w_next_b),
    .o_carry  (w_carry)
  );

  // Load suppresses valid so the element on the bus in that cycle is neither consumed nor lost.
  assign o_out_valid = i_en & ~i_load & ~rst & ((r_fsm == ST_RUN) | (r_fsm == ST_LAST));
  assign w_fire      = o_out_valid & i_out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= SEED0;
      r_b    <= SEED1;
      r_idx  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
      r_fsm  <= ST_RUN;
    end else if (i_load) begin
      r_a    <= i_seed_a;
      r_b    <= i_seed_b;
      r_idx  <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
      r_fsm  <= ST_RUN;
    end else if (w_fire) begin
      case (r_fsm)
        ST_RUN: begin
          r_a   <= w_next_a;
          r_b   <= w_next_b;
          r_idx <= r_idx + CNT_W'(1);
          if (w_carry) r_ovf <= 1'b1;
          if (!WRAP && w_carry) r_fsm <= ST_LAST;
        end
        ST_LAST: begin
          r_fsm  <= ST_DONE;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_out_data = r_a;
  assign o_out_idx  = r_idx;
  assign o_ovf      = r_ovf;
  assign o_done     = r_done;

endmodule
